// File: rtl/lever_frame_decoder.sv
// UART byte-stream to FD lever decoder: assembles HEADER-led frames into two signed
// 16-bit lever values. Optional trailing XOR checksum byte enabled by LEVER_CHECKSUM_EN.
module lever_frame_decoder #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         TIMEOUT_CYC = 50_000,
  parameter int         TO_W        = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] al1Bits,
  output logic [15:0] al2Bits,
  output logic        frame_ok,
  output logic        crc_err,
  output logic        timeout,
  output logic [7:0]  frame_cnt,
  output logic [3:0]  db_estado
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_AL1_H = 3'd1;
  localparam logic [2:0] S_AL1_L = 3'd2;
  localparam logic [2:0] S_AL2_H = 3'd3;
  localparam logic [2:0] S_AL2_L = 3'd4;
`ifdef LEVER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd5;
`endif

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [2:0]      state_q, state_d;
  logic [15:0]     al1_sh_q, al1_sh_d;
  logic [7:0]      al2_hi_q, al2_hi_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [15:0]     al1_q, al1_d;
  logic [15:0]     al2_q, al2_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            frame_ok_q, frame_ok_d;
  logic            timeout_q, timeout_d;
`ifdef LEVER_CHECKSUM_EN
  logic [7:0]      al2_lo_q, al2_lo_d;
  logic [7:0]      xor_q, xor_d;
  logic            crc_err_q, crc_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    al1_sh_d   = al1_sh_q;
    al2_hi_d   = al2_hi_q;
    to_cnt_d   = to_cnt_q;
    al1_d      = al1_q;
    al2_d      = al2_q;
    cnt_d      = cnt_q;
    frame_ok_d = 1'b0;
    timeout_d  = 1'b0;
`ifdef LEVER_CHECKSUM_EN
    al2_lo_d   = al2_lo_q;
    xor_d      = xor_q;
    crc_err_d  = 1'b0;
`endif

    if (state_q == S_IDLE) begin
      to_cnt_d = '0;
      if (rx_valid && (rx_data == HEADER)) begin
        state_d = S_AL1_H;
`ifdef LEVER_CHECKSUM_EN
        xor_d   = 8'h00;
`endif
      end
    end else if (rx_valid) begin
      // An accepted byte always wins over an expiring timeout in the same cycle.
      to_cnt_d = '0;
`ifdef LEVER_CHECKSUM_EN
      xor_d    = xor_q ^ rx_data;
`endif
      case (state_q)
        S_AL1_H: begin
          al1_sh_d[15:8] = rx_data;
          state_d        = S_AL1_L;
        end
        S_AL1_L: begin
          al1_sh_d[7:0] = rx_data;
          state_d       = S_AL2_H;
        end
        S_AL2_H: begin
          al2_hi_d = rx_data;
          state_d  = S_AL2_L;
        end
        S_AL2_L: begin
`ifdef LEVER_CHECKSUM_EN
          al2_lo_d = rx_data;
          state_d  = S_CHK;
`else
          al1_d      = al1_sh_q;
          al2_d      = {al2_hi_q, rx_data};
          cnt_d      = cnt_q + 8'd1;
          frame_ok_d = 1'b1;
          state_d    = S_IDLE;
`endif
        end
`ifdef LEVER_CHECKSUM_EN
        S_CHK: begin
          if (rx_data == xor_q) begin
            al1_d      = al1_sh_q;
            al2_d      = {al2_hi_q, al2_lo_q};
            cnt_d      = cnt_q + 8'd1;
            frame_ok_d = 1'b1;
          end else begin
            crc_err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end else if (to_cnt_q == TO_LAST) begin
      state_d   = S_IDLE;
      timeout_d = 1'b1;
      to_cnt_d  = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      al1_sh_q   <= '0;
      al2_hi_q   <= '0;
      to_cnt_q   <= '0;
      al1_q      <= '0;
      al2_q      <= '0;
      cnt_q      <= '0;
      frame_ok_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      al1_sh_q   <= al1_sh_d;
      al2_hi_q   <= al2_hi_d;
      to_cnt_q   <= to_cnt_d;
      al1_q      <= al1_d;
      al2_q      <= al2_d;
      cnt_q      <= cnt_d;
      frame_ok_q <= frame_ok_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef LEVER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      al2_lo_q  <= '0;
      xor_q     <= '0;
      crc_err_q <= 1'b0;
    end else begin
      al2_lo_q  <= al2_lo_d;
      xor_q     <= xor_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  assign al1Bits   = al1_q;
  assign al2Bits   = al2_q;
  assign frame_ok  = frame_ok_q;
  assign timeout   = timeout_q;
  assign frame_cnt = cnt_q;
  assign db_estado = {1'b0, state_q};

endmodule
